// File: rtl/req_debounce_latch8.sv
`default_nettype none
// ============================================================================
// Module   : req_debounce_latch8
// Purpose  : Eight-channel request front end for an 8-3 priority encoder.
//            Each raw active-low request line is passed through a 2-flop
//            synchroniser and a per-channel debouncer. A debounced press
//            (released->pressed) sets a sticky pending bit. The pending bit
//            is held until the consumer acknowledges that channel's code.
//            Pending bits are presented active-low to the encoder.
// Ports    : iClk      - clock, rising edge
//            iRst      - synchronous reset, active-high
//            iReq[7:0] - raw request lines, active-low, asynchronous
//            iEn       - capture enable; low drops newly debounced presses
//            iAckValid - one-cycle strobe clearing pending[iAckCode]
//            iAckCode  - channel index to clear
//            oData     - ~pending, feeds encoder data input
//            oEI       - encoder enable, active-low, registered ~iEn
//            oPendCnt  - number of pending channels, 0..8
//            oOvr      - sticky overrun flag (REQ_OVERRUN_EN only, else 0)
// Options  : define REQ_OVERRUN_EN to build the overrun detector
// Revision : 1.0 - initial release
// ============================================================================
module req_debounce_latch8 #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iReq,
  input  logic       iEn,
  input  logic       iAckValid,
  input  logic [2:0] iAckCode,
  output logic [7:0] oData,
  output logic       oEI,
  output logic [3:0] oPendCnt,
  output logic       oOvr
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] pending;
  logic [7:0] fall;
  logic [7:0] press;
  logic [7:0] ack_vec;
  logic [7:0] pending_next;

  // Two-flop synchroniser; reset to the released level.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= iReq;
      sync2 <= sync1;
    end
  end

  // Per-channel debouncer. The stable level flips only after DEB_CYCLES
  // consecutive synchronised samples disagree with it; any agreeing sample
  // restarts the count.
  for (genvar k = 0; k < 8; k++) begin : g_ch
    logic [7:0] cnt;
    logic       stab;

    always_ff @(posedge iClk) begin
      if (iRst) begin
        cnt  <= '0;
        stab <= 1'b1;
      end else if (sync2[k] == stab) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stab <= sync2[k];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end

    // Debounced 1->0 change happening on this edge.
    assign fall[k] = (sync2[k] != stab) && (cnt == CNT_LAST) && !sync2[k];
  end

  // Presses completing while capture is disabled are dropped, not deferred.
  assign press   = iEn ? fall : 8'h00;
  assign ack_vec = iAckValid ? (8'h01 << iAckCode) : 8'h00;

  // Clear first, then set: a same-edge press on the acked channel wins.
  assign pending_next = (pending & ~ack_vec) | press;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pending  <= '0;
      oPendCnt <= '0;
      oEI      <= 1'b1;
    end else begin
      pending  <= pending_next;
      oPendCnt <= 4'($countones(pending_next));
      oEI      <= ~iEn;
    end
  end

  assign oData = ~pending;

`ifdef REQ_OVERRUN_EN
  logic ovr;

  // A press landing on a channel that stays pending (no same-edge ack of it)
  // means an earlier request was never serviced.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ovr <= 1'b0;
    end else if (|(press & pending & ~ack_vec)) begin
      ovr <= 1'b1;
    end
  end

  assign oOvr = ovr;
`else
  assign oOvr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_debounce_latch8.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_debounce_latch8
// Purpose  : Self-checking bench for req_debounce_latch8. A behavioural model
//            predicts outputs after every clock edge and queues them; a
//            monitor pops one prediction per edge and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_debounce_latch8;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       ackv;
  logic [2:0] ackc;
  logic [7:0] data;
  logic       ei;
  logic [3:0] pcnt;
  logic       ovr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  req_debounce_latch8 #(.DEB_CYCLES(DEB)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iReq      (req),
    .iEn       (en),
    .iAckValid (ackv),
    .iAckCode  (ackc),
    .oData     (data),
    .oEI       (ei),
    .oPendCnt  (pcnt),
    .oOvr      (ovr)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ei;
    logic [3:0] cnt;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  // Model state: a two-deep delay line for the synchroniser, a window of the
  // last DEB synchronised samples, the debounced level and the pending set.
  logic [7:0] m_dly[$];
  logic [7:0] m_win[$];
  logic [7:0] m_stable;
  logic [7:0] m_pend;
  logic       m_en;
  logic       m_ovr;

  // Predict the state after the coming edge from the current inputs, wait
  // for that edge, queue the prediction, then step off the edge.
  task automatic step();
    exp_t       e;
    logic [7:0] s2v;
    logic [7:0] fall;
    logic [7:0] press;
    logic [7:0] ackvec;
    bit         all_diff;
    if (rst) begin
      m_dly.delete();
      m_dly.push_back(8'hFF);
      m_dly.push_back(8'hFF);
      m_win.delete();
      m_stable = 8'hFF;
      m_pend   = 8'h00;
      m_en     = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      s2v = m_dly.pop_front();
      m_dly.push_back(req);
      m_win.push_back(s2v);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      fall = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (m_win.size() == DEB) begin
          all_diff = 1'b1;
          foreach (m_win[i]) if (m_win[i][k] == m_stable[k]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_stable[k]) fall[k] = 1'b1;
            m_stable[k] = ~m_stable[k];
          end
        end
      end
      press  = en ? fall : 8'h00;
      ackvec = ackv ? (8'h01 << ackc) : 8'h00;
`ifdef REQ_OVERRUN_EN
      if ((press & m_pend & ~ackvec) != 8'h00) m_ovr = 1'b1;
`endif
      m_pend = (m_pend & ~ackvec) | press;
      m_en   = en;
    end
    e.data = ~m_pend;
    e.ei   = ~m_en;
    e.cnt  = 4'($countones(m_pend));
    e.ovr  = m_ovr;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic ack(input logic [2:0] code);
    ackv = 1'b1;
    ackc = code;
    step();
    ackv = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("oData",    data,          e.data);
      chk("oEI",      {7'd0, ei},    {7'd0, e.ei});
      chk("oPendCnt", {4'd0, pcnt},  {4'd0, e.cnt});
      chk("oOvr",     {7'd0, ovr},   {7'd0, e.ovr});
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    en   = 1'b1;
    ackv = 1'b0;
    ackc = 3'd0;

    // Reset with all lines asserted, then idle released.
    hold(2);
    rst = 1'b0;
    req = 8'hFF;
    hold(20);

    // Clean press of channel 2, release, acknowledge.
    req = 8'hFB;
    hold(8);
    req = 8'hFF;
    hold(8);
    ack(3'd2);
    hold(2);

    // Glitch of 3 samples rejected, then a held press accepted.
    req = 8'hDF;
    hold(3);
    req = 8'hFF;
    hold(8);
    req = 8'hDF;
    hold(8);
    req = 8'hFF;
    hold(8);
    ack(3'd5);

    // Two channels together; ack one, ack a non-pending code, ack the other.
    req = 8'h7E;
    hold(8);
    req = 8'hFF;
    hold(8);
    ack(3'd7);
    ack(3'd3);
    ack(3'd0);

    // Enable gating: press while disabled is dropped, re-press is captured.
    en  = 1'b0;
    req = 8'hFD;
    hold(8);
    en  = 1'b1;
    hold(4);
    req = 8'hFF;
    hold(8);
    req = 8'hFD;
    hold(8);
    req = 8'hFF;
    hold(6);
    ack(3'd1);

    // Channel 4: pend, re-press landing on the same edge as its ack,
    // then a re-press with no ack.
    req = 8'hEF;
    hold(8);
    req = 8'hFF;
    hold(8);
    req = 8'hEF;
    hold(5);
    ack(3'd4);
    hold(2);
    req = 8'hFF;
    hold(8);
    req = 8'hEF;
    hold(8);
    req = 8'hFF;
    hold(20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold(4);

    // Randomised traffic with slow-moving lines so both glitches and
    // full presses occur.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 15) == 0) req[k] = ~req[k];
      en   = ($urandom_range(0, 9) != 0);
      ackv = ($urandom_range(0, 3) == 0);
      ackc = 3'($urandom_range(0, 7));
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end
    rst  = 1'b0;
    ackv = 1'b0;
    hold(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
